// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the buffered UART transmitter
// Serializer state encoding, frame geometry and bit-time computation.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  function automatic int symbol_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with combinational head read
// Push is dropped when full and pop is dropped when empty, so callers may drive them freely.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
// Bytes queue in byte_fifo; the serializer pops back-to-back frames with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      data_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic                            serial_out,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int SYMBOL_EDGE_TIME = symbol_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(SYMBOL_EDGE_TIME);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic [7:0]    head;
  logic          serial_next;
  logic          tick;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;

  assign data_in_ready = ~full;
  assign push          = data_in_valid & data_in_ready;
  assign tx_busy       = (state != IDLE);
  assign tick          = (cyc == CW'(SYMBOL_EDGE_TIME - 1));

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (data_in),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      serial_out <= serial_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        state_next = START;
      end
      START: if (tick) state_next = DATA;
      DATA:  if (tick && bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
      STOP: if (tick) begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // serial_out is registered, so drive it from the state and shift value being entered.
  always_comb begin
    shift_next = shift;
    if (pop)                         shift_next = head;
    else if (state == DATA && tick)  shift_next = {1'b0, shift[7:1]};
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      shift <= shift_next;
      if (state == IDLE || pop || tick) cyc <= '0;
      else                              cyc <= cyc + CW'(1);
      if (state == START && tick)      bit_idx <= '0;
      else if (state == DATA && tick)  bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
// A bench-side UART receiver decodes frames and checks them against queued expected bytes.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready;
  logic       d_serial;
  logic       d_busy;
  logic [3:0] d_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCK_FREQ(10), .BAUD_RATE(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .reset(rst), .data_in(d_data), .data_in_valid(d_valid),
    .data_in_ready(d_ready), .serial_out(d_serial), .tx_busy(d_busy),
    .fifo_count(d_count)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc_cnt = 0;
  logic [7:0] exp_q[$];
  int         start_times[$];
  int         mon_t;
  logic [7:0] mon_rx;
  bit         mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Receiver for the 10-cycles-per-bit instance: samples mid-bit, abandons frames on reset.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (serial_out === 1'b0) begin
        mon_active = 1'b1;
        mon_t = 0;
        start_times.push_back(cyc_cnt);
      end
    end else begin
      mon_t++;
      if (mon_t == 5) begin
        check("rx_start_mid", serial_out, 0);
      end else if (mon_t >= 15 && mon_t <= 85 && (mon_t % 10) == 5) begin
        mon_rx[(mon_t-15)/10] = serial_out;
      end else if (mon_t == 95) begin
        check("rx_stop_bit", serial_out, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected_frame: got 0x%0h expected no frame", mon_rx);
        end else begin
          check("rx_byte", mon_rx, exp_q.pop_front());
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_one(input logic [7:0] b);
    @(posedge clk); #1;
    data_in = b;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic wait_drain(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!tx_busy && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, done, 1);
  endtask

  initial begin
    int   bcnt;
    int   lowcnt;
    bit   seen_high;
    bit   found;
    logic [7:0] rxd;
    logic stop_bit;

    rst = 1'b1;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    d_data = 8'h00;
    d_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_serial", serial_out, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ready", data_in_ready, 1);

    // Single frame 0xA5 with push-to-pop latency
    exp_q.push_back(8'hA5);
    push_one(8'hA5);
    @(negedge clk);
    check("a5_count_after_push", fifo_count, 1);
    check("a5_idle_before_pop", tx_busy, 0);
    @(negedge clk);
    check("a5_start_low", serial_out, 0);
    check("a5_count_after_pop", fifo_count, 0);
    bcnt = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
      bcnt++;
    end
    check("a5_busy_cycles", bcnt, 100);
    check("a5_idle_line", serial_out, 1);

    // Back-to-back 0x00, 0xFF
    start_times.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(posedge clk); #1;
    data_in = 8'h00;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in = 8'hFF;
    @(negedge clk);
    check("b2b_count_first", fifo_count, 1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in = 8'h33;
    @(negedge clk);
    check("b2b_count_push_pop", fifo_count, 1);
    bcnt = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
      bcnt++;
    end
    check("b2b_busy_cycles", bcnt, 200);
    check("b2b_count_end", fifo_count, 0);
    check("b2b_frames", start_times.size(), 2);
    if (start_times.size() == 2)
      check("b2b_start_spacing", start_times[1] - start_times[0], 100);

    // Fill to full with valid held
    @(posedge clk); #1;
    data_in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data_in = 8'(k);
      if (k <= 9) exp_q.push_back(8'(k));
      @(negedge clk);
      if (k == 9) begin
        check("fill_count_k9", fifo_count, 7);
        check("fill_ready_k9", data_in_ready, 1);
      end
      if (k == 10) begin
        check("fill_ready_full", data_in_ready, 0);
        check("fill_count_full", fifo_count, 8);
      end
      @(posedge clk); #1;
    end
    data_in = 8'h0B;
    @(negedge clk);
    check("full_0a_dropped", fifo_count, 8);

    // Pop while full with valid held: no push on that edge
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (data_in_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("full_ready_rise", found, 1);
    check("full_count_after_pop", fifo_count, 7);
    exp_q.push_back(8'h0B);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in = 8'hEE;
    @(negedge clk);
    check("full_count_refill", fifo_count, 8);
    check("full_ready_refill", data_in_ready, 0);
    wait_drain(2000, "full_drain");
    check("full_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a 0x5A frame
    @(posedge clk); #1;
    data_in = 8'h5A;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    data_in = 8'h00;
    @(posedge clk);
    repeat (35) @(posedge clk);
    #2;
    check("rst_mid_line_low", serial_out, 0);
    check("rst_mid_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    check("rst_async_serial", serial_out, 1);
    check("rst_async_count", fifo_count, 0);
    check("rst_async_busy", tx_busy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(8'h3C);
    push_one(8'h3C);
    wait_drain(300, "rst_3c_drain");
    check("rst_queue_empty", exp_q.size(), 0);

    // Default parameters: 125 cycles per bit
    @(posedge clk); #1;
    d_data = 8'h55;
    d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    d_data = 8'h00;
    @(negedge clk);
    check("def_idle_before_pop", d_busy, 0);
    @(negedge clk);
    check("def_start_low", d_serial, 0);
    bcnt = 0;
    lowcnt = 0;
    seen_high = 1'b0;
    rxd = 8'h00;
    stop_bit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0) @(negedge clk);
      if (!d_busy) break;
      bcnt++;
      if (!seen_high && d_serial == 1'b0) lowcnt++;
      else seen_high = 1'b1;
      if (i >= 187 && i < 1125 && ((i - 187) % 125) == 0) rxd[(i-187)/125] = d_serial;
      if (i == 1187) stop_bit = d_serial;
    end
    check("def_start_width", lowcnt, 125);
    check("def_frame_cycles", bcnt, 1250);
    check("def_rx_byte", rxd, 8'h55);
    check("def_stop_bit", stop_bit, 1);
    check("def_idle_line", d_serial, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmit path, sitting directly downstream of the memory-mapped UART register wrapper's TX data register (address offset 0x8).
- Accepts bytes over a valid/ready handshake and queues them in an internal FIFO.
- Serializes each byte as 8N1 frames (start bit, 8 data bits LSB-first, stop bit) on serial_out.
- Decouples CPU byte writes from the slow bit rate, so software can burst up to FIFO_DEPTH bytes without polling between each one.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 1_000_000, line rate in bits/s; SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer, must be >= 2)
FIFO_DEPTH, 8, byte entries; power of two, >= 2

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  8  byte to transmit
data_in_valid  input  1  data_in is presented
data_in_ready  output  1  FIFO can accept a byte (not full)
serial_out  output  1  UART TX line, idle high
tx_busy  output  1  serializer is mid-frame (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte being shifted

Behaviour:
- Reset values: serial_out=1, tx_busy=0, fifo_count=0, data_in_ready=1, state=IDLE, bit counter=0, cycle counter=0, FIFO pointers=0.
- Push handshake:
  - A push occurs on an edge where data_in_valid & data_in_ready.
  - data_in_ready = (fifo_count != FIFO_DEPTH), combinational from count only.
  - When full, no push occurs even if a pop happens on the same edge.
- Pop: the serializer pops the head on an edge where it is in IDLE (or finishing STOP) and fifo_count != 0.
- Simultaneous push and pop (not full): fifo_count is unchanged; pointers both advance and wrap modulo FIFO_DEPTH.
- Serializer FSM (serial_out is registered):
  - IDLE: serial_out=1. If FIFO is non-empty: pop, load the shift register, clear the cycle counter, go to START.
  - START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA with bit index 0.
  - DATA: serial_out=shift[0] for SYMBOL_EDGE_TIME cycles per bit. Shift right after each bit. After bit 7 go to STOP.
  - STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles. At the end:
    - FIFO non-empty: pop, go directly to START (zero idle cycles between frames).
    - FIFO empty: go to IDLE.
- Latency and timing:
  - A byte pushed into an empty FIFO with an idle serializer at edge N is popped at edge N+1; serial_out goes low after edge N+1.
  - A frame lasts exactly 10*SYMBOL_EDGE_TIME cycles.
- Cycle counter: width $clog2(SYMBOL_EDGE_TIME). It counts 0..SYMBOL_EDGE_TIME-1 and wraps; the bit advances on the wrap.
- data_in is sampled only on push; later changes to data_in do not affect queued bytes.
- Reset mid-frame: serial_out returns to 1 asynchronously, the FIFO is emptied, and the partial frame is abandoned (no completion).
- data_in_valid while not ready: the byte is ignored. The upstream stage must hold or retry; no error flag is raised.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, STOP (2 bits);
  - DATA_BITS=8 and FRAME_BITS=10;
  - a symbol-time function computing CLOCK_FREQ/BAUD_RATE.
- One sub-module: byte_fifo.
  - Parameterized by WIDTH and DEPTH.
  - Interface: push/pop/full/empty/count; head is combinational read of the head entry.
  - uart_tx_fifo instantiates it and contains the serializer FSM.

Test Plan:
- CLOCK_FREQ=10, BAUD_RATE=1 (10 cycles/bit); push 0xA5 once -> serial_out per 10-cycle bit: 0,1,0,1,0,0,1,0,1,1; then idle high; tx_busy high for exactly 100 cycles.
- Push 0x00 then 0xFF on consecutive cycles -> two contiguous 100-cycle frames with no idle gap between the stop bit and the next start bit; fifo_count shows 1 then 0.
- Hold data_in_valid for 10 consecutive cycles (bytes 0x01..0x0A), FIFO_DEPTH=8 -> 9 bytes accepted (first one popped immediately); data_in_ready=0 on cycle 10; fifo_count=8; 0x0A never transmitted.
- While full, a pop occurs (frame ends) with valid held -> no push that edge; ready rises next cycle; the next push is accepted; fifo_count returns to 8.
- Assert reset at cycle 35 of a 0x5A frame -> serial_out=1 within the same cycle (async); fifo_count=0; tx_busy=0. After release, push 0x3C -> clean full 0x3C frame.
- Default parameters (125 cycles/bit); push 0x55 -> start-bit low width measured exactly 125 cycles; total frame 1250 cycles.
